// File: rtl/rs485_tx_scheduler_pkg.sv
// Shared types and helpers for the RS485 transmit scheduler: FSM encoding and
// bit-time arithmetic used to derive guard and timeout defaults.
package rs485_tx_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_LOAD = 3'd2,
    ST_WAIT = 3'd3,
    ST_POST = 3'd4
  } state_t;

  // Clock cycles per UART bit, truncated.
  function automatic int bit_cyc(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rs485_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant of the first valid requester
// found when searching upward from ptr, wrapping at NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [2:0]         grant_idx,
  output logic               any_req
);

  int   idx;
  logic hit;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    idx       = 0;
    hit       = 1'b0;
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      hit = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (j == idx) hit = req[j];
      end
      if (hit && !any_req) begin
        any_req   = 1'b1;
        grant_idx = 3'(idx);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      grant[j] = any_req && (grant_idx == 3'(j));
    end
  end

endmodule

// File: rtl/rs485_tx_scheduler.sv
// Shares one uart_tx and the half-duplex RS485 line among NUM_REQ byte producers,
// owning the driver enable with pre/post turnaround guards and a done timeout.
module rs485_tx_scheduler
  import rs485_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int CLK_FREQ       = 50_000_000,
  parameter int UART_BPS       = 115200,
  parameter int GUARD_PRE_CYC  = 50,
  parameter int GUARD_POST_CYC = bit_cyc(CLK_FREQ, UART_BPS),
  parameter int TIMEOUT_CYC    = bit_cyc(12 * CLK_FREQ, UART_BPS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [2:0]           grant_id,
  input  logic                 rx_active,
  input  logic                 tx_busy,
  input  logic                 uart_tx_done,
  output logic                 uart_tx_start,
  output logic [7:0]           uart_tx_data,
  output logic                 en_rs485,
  output logic                 tx_timeout
);

  localparam int CNT_MAX = max3(GUARD_PRE_CYC, GUARD_POST_CYC, TIMEOUT_CYC);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(GUARD_PRE_CYC - 1);
  localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(GUARD_POST_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [2:0]         rr_ptr, rr_ptr_nxt;

  logic [NUM_REQ-1:0] arb_grant;
  logic [2:0]         arb_idx;
  logic               arb_any;
  logic               grant_fire;

  logic [NUM_REQ-1:0] req_ready_nxt;
  logic [2:0]         grant_id_nxt;
  logic [7:0]         data_nxt;
  logic               start_nxt;
  logic               en_nxt;
  logic               timeout_nxt;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  // Requests are only looked at in IDLE (gated by the receiver) and in POST (burst continuation).
  assign grant_fire = ((state == ST_IDLE) && arb_any && !rx_active) ||
                      ((state == ST_POST) && arb_any);

  // NOTE: sequential state uses non-blocking assignments; async reset clears every register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      rr_ptr        <= '0;
      req_ready     <= '0;
      grant_id      <= '0;
      uart_tx_start <= 1'b0;
      uart_tx_data  <= '0;
      en_rs485      <= 1'b0;
      tx_timeout    <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      rr_ptr        <= rr_ptr_nxt;
      req_ready     <= req_ready_nxt;
      grant_id      <= grant_id_nxt;
      uart_tx_start <= start_nxt;
      uart_tx_data  <= data_nxt;
      en_rs485      <= en_nxt;
      tx_timeout    <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (grant_fire) begin
          state_nxt = ST_PRE;
          cnt_nxt   = '0;
        end
      end
      ST_PRE: begin
        if (cnt == PRE_LAST) begin
          state_nxt = ST_LOAD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_LOAD: begin
        if (!tx_busy) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT: begin
        // A done arriving on the timeout cycle wins: the byte went out.
        if (uart_tx_done || (cnt == TO_LAST)) begin
          state_nxt = ST_POST;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_POST: begin
        if (grant_fire) begin
          state_nxt = ST_LOAD;
          cnt_nxt   = '0;
        end else if (cnt == POST_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    req_ready_nxt = grant_fire ? arb_grant : '0;
    grant_id_nxt  = grant_fire ? arb_idx : grant_id;
    data_nxt      = uart_tx_data;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_fire && arb_grant[i]) data_nxt = req_data[8*i +: 8];
    end
    start_nxt   = (state == ST_LOAD) && !tx_busy;
    timeout_nxt = (state == ST_WAIT) && !uart_tx_done && (cnt == TO_LAST);
    en_nxt      = (state_nxt != ST_IDLE);
    rr_ptr_nxt  = rr_ptr;
    if (grant_fire) begin
      rr_ptr_nxt = (arb_idx == 3'(NUM_REQ - 1)) ? 3'd0 : arb_idx + 3'd1;
    end
  end

endmodule

// File: tb/tb_rs485_tx_scheduler.sv
// Self-checking bench for rs485_tx_scheduler: vector table of single-byte
// transactions, scoreboard on uart_tx_start, and hand-written corner sequences.
module tb_rs485_tx_scheduler;

  localparam int NUM_REQ        = 2;
  localparam int CLK_FREQ       = 50_000_000;
  localparam int UART_BPS       = 115200;
  localparam int GUARD_PRE_CYC  = 50;
  localparam int GUARD_POST_CYC = CLK_FREQ / UART_BPS;       // 434
  localparam int TIMEOUT_CYC    = 12 * CLK_FREQ / UART_BPS;  // 5208

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic [2:0]  grant_id;
  logic        rx_active;
  logic        tx_busy;
  logic        uart_tx_done;
  logic        uart_tx_start;
  logic [7:0]  uart_tx_data;
  logic        en_rs485;
  logic        tx_timeout;

  rs485_tx_scheduler #(
    .NUM_REQ        (NUM_REQ),
    .CLK_FREQ       (CLK_FREQ),
    .UART_BPS       (UART_BPS),
    .GUARD_PRE_CYC  (GUARD_PRE_CYC),
    .GUARD_POST_CYC (GUARD_POST_CYC),
    .TIMEOUT_CYC    (TIMEOUT_CYC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .grant_id      (grant_id),
    .rx_active     (rx_active),
    .tx_busy       (tx_busy),
    .uart_tx_done  (uart_tx_done),
    .uart_tx_start (uart_tx_start),
    .uart_tx_data  (uart_tx_data),
    .en_rs485      (en_rs485),
    .tx_timeout    (tx_timeout)
  );

  typedef enum int {EV_READY, EV_START, EV_DONE, EV_EN_LOW, EV_TIMEOUT} ev_t;

  typedef struct {
    logic [1:0] valid;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] exp_ready;
    logic [2:0] exp_gid;
    logic [7:0] exp_data;
  } vec_t;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] sb_q[$];
  bit         suppress_done = 1'b0;
  int         done_dly = 20;
  int         done_cnt = 0;
  int         de_low_cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit probe(input ev_t ev);
    case (ev)
      EV_READY:   return |req_ready;
      EV_START:   return uart_tx_start;
      EV_DONE:    return uart_tx_done;
      EV_EN_LOW:  return !en_rs485;
      EV_TIMEOUT: return tx_timeout;
      default:    return 1'b0;
    endcase
  endfunction

  // Counts falling edges until the event is visible; an expired bound is a failure.
  task automatic wait_for(input ev_t ev, input int max, input string what, output int cyc);
    cyc = 0;
    while (!probe(ev) && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
    if (!probe(ev)) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: event not seen within %0d cycles", what, max);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b0;
    @(negedge clk);
    check("reset_state",
          32'({en_rs485, uart_tx_start, req_ready, grant_id, uart_tx_data, tx_timeout}), 32'h0);
    rst_n = 1'b1;
  endtask

  // uart_tx model and scoreboard: inputs change 2 ns after the rising edge.
  initial begin
    uart_tx_done = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      uart_tx_done = 1'b0;
      if (!en_rs485) de_low_cyc++;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) uart_tx_done = 1'b1;
      end
      if (uart_tx_start) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_empty: start with data 0x%0h, expected no byte", uart_tx_data);
        end else begin
          check("sb_data", 32'(uart_tx_data), 32'(sb_q.pop_front()));
        end
        if (!suppress_done) done_cnt = done_dly;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[6];
    int         cyc;
    int         de_base;
    int         starts;
    int         start_at;
    logic       blocked;
    logic [1:0] exp_ready;

    // Round-robin pointer starts at req 0 and moves past each grant.
    vecs[0] = '{valid: 2'b01, d0: 8'h03, d1: 8'h00, exp_ready: 2'b01, exp_gid: 3'd0, exp_data: 8'h03};
    vecs[1] = '{valid: 2'b11, d0: 8'hA1, d1: 8'hB2, exp_ready: 2'b10, exp_gid: 3'd1, exp_data: 8'hB2};
    vecs[2] = '{valid: 2'b11, d0: 8'hC3, d1: 8'hD4, exp_ready: 2'b01, exp_gid: 3'd0, exp_data: 8'hC3};
    vecs[3] = '{valid: 2'b01, d0: 8'hE5, d1: 8'h00, exp_ready: 2'b01, exp_gid: 3'd0, exp_data: 8'hE5};
    vecs[4] = '{valid: 2'b10, d0: 8'h00, d1: 8'hFF, exp_ready: 2'b10, exp_gid: 3'd1, exp_data: 8'hFF};
    vecs[5] = '{valid: 2'b11, d0: 8'h00, d1: 8'h7E, exp_ready: 2'b01, exp_gid: 3'd0, exp_data: 8'h00};

    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rx_active = 1'b0;
    tx_busy   = 1'b0;
    repeat (2) @(negedge clk);
    apply_reset();

    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      req_valid = vecs[v].valid;
      req_data  = {vecs[v].d1, vecs[v].d0};
      sb_q.push_back(vecs[v].exp_data);
      wait_for(EV_READY, 10, "vec_ready", cyc);
      check($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(vecs[v].exp_ready));
      check($sformatf("vec%0d_grant_id", v), 32'(grant_id), 32'(vecs[v].exp_gid));
      check($sformatf("vec%0d_de_up", v), 32'(en_rs485), 32'h1);
      req_valid = '0;
      @(negedge clk);
      check($sformatf("vec%0d_ready_pulse", v), 32'(req_ready), 32'h0);
      wait_for(EV_START, 200, "vec_start", cyc);
      check($sformatf("vec%0d_start_latency", v), 32'(cyc + 1), 32'(GUARD_PRE_CYC + 1));
      check($sformatf("vec%0d_data", v), 32'(uart_tx_data), 32'(vecs[v].exp_data));
      @(negedge clk);
      check($sformatf("vec%0d_start_pulse", v), 32'(uart_tx_start), 32'h0);
      wait_for(EV_DONE, 100, "vec_done", cyc);
      // done is sampled on the edge after it is observed, hence the +1.
      wait_for(EV_EN_LOW, 1000, "vec_de_drop", cyc);
      check($sformatf("vec%0d_de_post_guard", v), 32'(cyc), 32'(GUARD_POST_CYC + 1));
    end

    // Two requesters held valid: alternating bytes in one burst with a single PRE.
    apply_reset();
    @(negedge clk);
    req_data  = {8'hAA, 8'h55};
    req_valid = 2'b11;
    sb_q.push_back(8'h55);
    sb_q.push_back(8'hAA);
    sb_q.push_back(8'h55);
    sb_q.push_back(8'hAA);
    de_base = 0;
    for (int k = 0; k < 4; k++) begin
      wait_for(EV_READY, 600, "burst_ready", cyc);
      if (k == 0) de_base = de_low_cyc;
      exp_ready = (k % 2 == 0) ? 2'b01 : 2'b10;
      check($sformatf("burst%0d_ready", k), 32'(req_ready), 32'(exp_ready));
      check($sformatf("burst%0d_grant_id", k), 32'(grant_id), 32'(k % 2));
      if (k == 3) req_valid = '0;
      wait_for(EV_START, 200, "burst_start", cyc);
      check($sformatf("burst%0d_start_latency", k), 32'(cyc),
            32'((k == 0) ? GUARD_PRE_CYC + 1 : 1));
    end
    wait_for(EV_DONE, 100, "burst_done", cyc);
    check("burst_de_continuous", 32'(de_low_cyc - de_base), 32'h0);
    wait_for(EV_EN_LOW, 1000, "burst_de_drop", cyc);

    // Receiver activity blocks a new burst from IDLE.
    @(negedge clk);
    rx_active = 1'b1;
    req_data  = {8'h3C, 8'h00};
    req_valid = 2'b10;
    sb_q.push_back(8'h3C);
    blocked = 1'b0;
    repeat (10) begin
      @(negedge clk);
      blocked = blocked | en_rs485 | (|req_ready);
    end
    check("rx_block", 32'(blocked), 32'h0);
    rx_active = 1'b0;
    @(negedge clk);
    check("rx_release_ready", 32'(req_ready), 32'h2);
    check("rx_release_grant_id", 32'(grant_id), 32'h1);
    check("rx_release_de", 32'(en_rs485), 32'h1);
    req_valid = '0;
    wait_for(EV_EN_LOW, 2000, "rx_de_drop", cyc);

    // Missing done: timeout pulse, then normal post guard.
    suppress_done = 1'b1;
    @(negedge clk);
    req_data  = {8'h00, 8'h81};
    req_valid = 2'b01;
    sb_q.push_back(8'h81);
    wait_for(EV_READY, 10, "to_ready", cyc);
    req_valid = '0;
    wait_for(EV_START, 200, "to_start", cyc);
    wait_for(EV_TIMEOUT, TIMEOUT_CYC + 100, "to_pulse", cyc);
    check("timeout_latency", 32'(cyc), 32'(TIMEOUT_CYC));
    check("timeout_de_held", 32'(en_rs485), 32'h1);
    @(negedge clk);
    check("timeout_pulse_width", 32'(tx_timeout), 32'h0);
    wait_for(EV_EN_LOW, 1000, "to_de_drop", cyc);
    check("timeout_de_post_guard", 32'(cyc + 1), 32'(GUARD_POST_CYC));
    suppress_done = 1'b0;

    // done lands on the very cycle the timeout would fire: no timeout pulse.
    done_dly = TIMEOUT_CYC - 1;
    @(negedge clk);
    req_data  = {8'h00, 8'h18};
    req_valid = 2'b01;
    sb_q.push_back(8'h18);
    wait_for(EV_READY, 10, "co_ready", cyc);
    req_valid = '0;
    wait_for(EV_START, 200, "co_start", cyc);
    wait_for(EV_DONE, TIMEOUT_CYC + 100, "co_done", cyc);
    @(negedge clk);
    check("coincident_no_timeout", 32'(tx_timeout), 32'h0);
    wait_for(EV_EN_LOW, 1000, "co_de_drop", cyc);
    check("coincident_de_post_guard", 32'(cyc + 1), 32'(GUARD_POST_CYC + 1));
    done_dly = 20;

    // tx_busy holds LOAD for 20 cycles; start comes on the first idle cycle, once.
    @(negedge clk);
    tx_busy   = 1'b1;
    req_data  = {8'h00, 8'h5A};
    req_valid = 2'b01;
    sb_q.push_back(8'h5A);
    wait_for(EV_READY, 10, "busy_ready", cyc);
    req_valid = '0;
    starts   = 0;
    start_at = -1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (uart_tx_start) begin
        starts++;
        if (start_at < 0) start_at = k;
      end
      if (k == GUARD_PRE_CYC + 20) tx_busy = 1'b0;
    end
    check("busy_start_count", 32'(starts), 32'h1);
    check("busy_start_time", 32'(start_at), 32'(GUARD_PRE_CYC + 21));
    wait_for(EV_EN_LOW, 2000, "busy_de_drop", cyc);

    // Asynchronous reset in WAIT, then round robin restarts at req 0.
    suppress_done = 1'b1;
    @(negedge clk);
    req_data  = {8'h00, 8'h42};
    req_valid = 2'b01;
    sb_q.push_back(8'h42);
    wait_for(EV_READY, 10, "ar_ready", cyc);
    req_valid = '0;
    wait_for(EV_START, 200, "ar_start", cyc);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          32'({en_rs485, uart_tx_start, req_ready, grant_id, uart_tx_data, tx_timeout}), 32'h0);
    @(negedge clk);
    suppress_done = 1'b0;
    req_data  = {8'h99, 8'h77};
    req_valid = 2'b11;
    sb_q.push_back(8'h77);
    sb_q.push_back(8'h99);
    @(negedge clk);
    rst_n = 1'b1;
    wait_for(EV_READY, 10, "ar_first_ready", cyc);
    check("ar_first_ready", 32'(req_ready), 32'h1);
    check("ar_first_grant_id", 32'(grant_id), 32'h0);
    req_valid = 2'b10;
    wait_for(EV_START, 200, "ar_first_start", cyc);
    wait_for(EV_READY, 600, "ar_second_ready", cyc);
    check("ar_second_ready", 32'(req_ready), 32'h2);
    check("ar_second_grant_id", 32'(grant_id), 32'h1);
    req_valid = '0;
    wait_for(EV_EN_LOW, 2000, "ar_de_drop", cyc);

    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
